// File: rtl/rfx_prescaler_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : rfx_prescaler_cfg_seq
// Purpose  : AXI4-Lite master that programs the rfx_prescaler register bank
//            from a parallel configuration word set. A start pulse latches
//            cfg_data. Each register is then written in ascending address
//            order, optionally read back and compared, and the sequence ends
//            with a one-cycle done pulse or a sticky error flag.
// Build option:
//   RFX_PRESC_CFG_READBACK_EN - when defined, every write is followed by a
//            readback compare (RADDR/RDATA states). When undefined, the read
//            channel is tied off and only write responses can flag an error.
// Ports    :
//   ACLK, ARESETN        clock, synchronous active-low reset
//   start, cfg_data      sequence request and register values (word i at
//                        bits [32*i+31:32*i])
//   busy, done           sequence in progress / successful completion pulse
//   error, err_index     sticky failure flag and failing register index
//   m_axi_aw*/w*/b*      AXI4-Lite write address / data / response channels
//   m_axi_ar*/r*         AXI4-Lite read address / data channels
// Revision : 1.0 - initial release
// ============================================================================
module rfx_prescaler_cfg_seq #(
  parameter logic [31:0] C_BASE_ADDR = 32'h43C0_0000,
  parameter int unsigned C_NUM_REGS  = 4
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      start,
  input  logic [32*C_NUM_REGS-1:0]  cfg_data,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [3:0]                err_index,
  output logic [31:0]               m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [31:0]               m_axi_wdata,
  output logic [3:0]                m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [31:0]               m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [31:0]               m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam logic [3:0] LAST_IDX = 4'(C_NUM_REGS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
`ifdef RFX_PRESC_CFG_READBACK_EN
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
`endif
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  state_t                    state_q, state_d;
  logic [3:0]                index_q, index_d;
  logic [32*C_NUM_REGS-1:0]  cfg_q, cfg_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      error_q, error_d;
  logic [3:0]                err_index_q, err_index_d;

  logic [31:0]               w_addr;
  logic [31:0]               w_word;
  logic                      w_aw_ok;
  logic                      w_w_ok;
  logic                      w_advance;

  // Address and data are pure functions of the index, so they stay stable
  // for as long as the matching valid is held.
  assign w_addr = C_BASE_ADDR + {26'd0, index_q, 2'b00};
  assign w_word = cfg_q[{index_q, 5'd0} +: 32];

  // A channel counts as accepted when its valid is already low inside WRITE
  // (handshake done earlier) or when the handshake completes this cycle.
  assign w_aw_ok = !awvalid_q || m_axi_awready;
  assign w_w_ok  = !wvalid_q  || m_axi_wready;

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    cfg_d       = cfg_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    error_d     = error_q;
    err_index_d = err_index_q;
    w_advance   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          cfg_d       = cfg_data;
          index_d     = 4'd0;
          error_d     = 1'b0;
          err_index_d = 4'd0;
          awvalid_d   = 1'b1;
          wvalid_d    = 1'b1;
          state_d     = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WRITE: begin
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (w_aw_ok && w_w_ok)          state_d   = ST_WRESP;
      end

      ST_WRESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) begin
            error_d     = 1'b1;
            err_index_d = index_q;
            state_d     = ST_ERR;
          end else begin
`ifdef RFX_PRESC_CFG_READBACK_EN
            state_d = ST_RADDR;
`else
            w_advance = 1'b1;
`endif
          end
        end
      end

`ifdef RFX_PRESC_CFG_READBACK_EN
      ST_RADDR: begin
        if (m_axi_arready) state_d = ST_RDATA;
      end

      ST_RDATA: begin
        if (m_axi_rvalid) begin
          if ((m_axi_rresp != 2'b00) || (m_axi_rdata != w_word)) begin
            error_d     = 1'b1;
            err_index_d = index_q;
            state_d     = ST_ERR;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    if (w_advance) begin
      if (index_q == LAST_IDX) begin
        state_d = ST_DONE;
      end else begin
        index_d   = index_q + 4'd1;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        state_d   = ST_WRITE;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q     <= ST_IDLE;
      index_q     <= 4'd0;
      cfg_q       <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      cfg_q       <= cfg_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
    end
  end

  // busy covers only the AXI phases so it drops in the same cycle that done
  // or error first becomes visible.
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
  assign done      = (state_q == ST_DONE);
  assign error     = error_q;
  assign err_index = err_index_q;

  assign m_axi_awaddr  = w_addr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = w_word;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == ST_WRESP);
  assign m_axi_araddr  = w_addr;
  assign m_axi_arprot  = 3'b000;

`ifdef RFX_PRESC_CFG_READBACK_EN
  assign m_axi_arvalid = (state_q == ST_RADDR);
  assign m_axi_rready  = (state_q == ST_RDATA);
`else
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = 1'b0;

  // Read channel inputs have no consumer without readback.
  logic w_unused_rd;
  assign w_unused_rd = ^{m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid};
`endif

endmodule
`default_nettype wire
